// File: rtl/unsat_clause_picker.sv
// Scans a snapshot of per-clause satisfied flags one clause per cycle from an
// LFSR-chosen (or zero) offset and reports the first unsatisfied clause found.
module unsat_clause_picker #(
  parameter int          NUMBER_OF_CLAUSES                  = 2,
  parameter int          MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX = 1,
  parameter logic [15:0] LFSR_SEED                          = 16'hACE1
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          in_start,
  input  logic                                          in_setting,
  input  logic [NUMBER_OF_CLAUSES-1:0]                  in_clause_satisfied,
  output logic                                          out_busy,
  output logic                                          out_done,
  output logic [MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX-1:0] out_clause_index,
  output logic                                          out_clause_satisfied
);
  localparam int N = NUMBER_OF_CLAUSES;
  localparam int W = MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t         state, state_nxt;
  logic [15:0]    lfsr;
  logic           fb;
  logic [N-1:0]   snap, snap_nxt;
  logic [W-1:0]   ptr, ptr_nxt, cnt, cnt_nxt;
  logic [W-1:0]   idx_nxt, r, rand_ptr;
  logic           sat_nxt;

  assign fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // r < 2N, so a single conditional subtraction folds it into [0, N)
  assign r        = lfsr[W-1:0];
  assign rand_ptr = ({1'b0, r} >= (W+1)'(N)) ? r - W'(N) : r;

  assign out_busy = (state != IDLE);
  assign out_done = (state == DONE);

  always_comb begin
    state_nxt = state;
    snap_nxt  = snap;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    idx_nxt   = out_clause_index;
    sat_nxt   = out_clause_satisfied;
    case (state)
      IDLE: begin
        if (in_start) begin
          snap_nxt  = in_clause_satisfied;
          ptr_nxt   = in_setting ? '0 : rand_ptr;
          cnt_nxt   = '0;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (!snap[ptr]) begin
          idx_nxt   = ptr;
          sat_nxt   = 1'b0;
          state_nxt = DONE;
        end else if (cnt == W'(N-1)) begin
          idx_nxt   = '0;
          sat_nxt   = 1'b1;
          state_nxt = DONE;
        end else begin
          ptr_nxt = (ptr == W'(N-1)) ? '0 : ptr + W'(1);
          cnt_nxt = cnt + W'(1);
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= IDLE;
      lfsr                 <= LFSR_SEED;
      snap                 <= '0;
      ptr                  <= '0;
      cnt                  <= '0;
      out_clause_index     <= '0;
      out_clause_satisfied <= 1'b0;
    end else begin
      state                <= state_nxt;
      lfsr                 <= {lfsr[14:0], fb};
      snap                 <= snap_nxt;
      ptr                  <= ptr_nxt;
      cnt                  <= cnt_nxt;
      out_clause_index     <= idx_nxt;
      out_clause_satisfied <= sat_nxt;
    end
  end
endmodule

// File: tb/tb_unsat_clause_picker.sv
// Randomized bench for unsat_clause_picker (N=4 and N=3 instances) against a
// behavioural pick model driven by a free-running reference LFSR.
module tb_unsat_clause_picker;
  logic       clk = 1'b0;
  logic       reset;
  logic       st4, set4, busy4, done4, sat4;
  logic [3:0] fl4;
  logic [1:0] idx4;
  logic       st3, set3, busy3, done3, sat3;
  logic [2:0] fl3;
  logic [1:0] idx3;
  logic [15:0] m_lfsr;
  int passed = 0, total = 0;

  always #5 clk = ~clk;

  unsat_clause_picker #(.NUMBER_OF_CLAUSES(4), .MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX(2),
                        .LFSR_SEED(16'hACE1)) u4 (
    .clk(clk), .reset(reset), .in_start(st4), .in_setting(set4), .in_clause_satisfied(fl4),
    .out_busy(busy4), .out_done(done4), .out_clause_index(idx4), .out_clause_satisfied(sat4));

  unsat_clause_picker #(.NUMBER_OF_CLAUSES(3), .MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX(2),
                        .LFSR_SEED(16'hACE1)) u3 (
    .clk(clk), .reset(reset), .in_start(st3), .in_setting(set3), .in_clause_satisfied(fl3),
    .out_busy(busy3), .out_done(done3), .out_clause_index(idx3), .out_clause_satisfied(sat3));

  // Reference LFSR: x^16+x^14+x^13+x^11+1, stepped every cycle
  always @(posedge clk)
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else passed++;
  endtask

  // Behavioural pick: k = number of clauses examined = edges from accept to out_done
  function automatic void ref_pick(input int n, input int flags, input bit setting,
                                   input int lfsrv, output int idx, output int sat, output int k);
    int start;
    bit found;
    start = setting ? 0 : (lfsrv % 4) % n;
    idx = 0; sat = 1; k = n; found = 0;
    for (int i = 0; i < n; i++) begin
      int c;
      c = (start + i) % n;
      if (!found && ((flags >> c) & 1) == 0) begin
        idx = c; sat = 0; k = i + 1; found = 1;
      end
    end
  endfunction

  task automatic pick(input bit n3, input int flags, input bit setting,
                      output int lat, output int idx, output int sat, output int lfsrv);
    @(negedge clk);
    lfsrv = m_lfsr;
    if (n3) begin fl3 = flags[2:0]; set3 = setting; st3 = 1'b1; end
    else    begin fl4 = flags[3:0]; set4 = setting; st4 = 1'b1; end
    @(negedge clk);
    st3 = 1'b0; st4 = 1'b0;
    chk("busy_after_start", n3 ? busy3 : busy4, 1);
    lat = -1;
    for (int e = 1; e <= 20 && lat < 0; e++) begin
      @(negedge clk);
      if (n3 ? done3 : done4) lat = e;
    end
    if (lat < 0) chk("done_timeout", 0, 1);
    idx = n3 ? idx3 : idx4;
    sat = n3 ? sat3 : sat4;
  endtask

  task automatic pick_vs_model(input string tag, input bit n3, input int flags, input bit setting,
                               output int idx, output int lat);
    int sat, lv, e_idx, e_sat, e_k;
    pick(n3, flags, setting, lat, idx, sat, lv);
    ref_pick(n3 ? 3 : 4, flags, setting, lv, e_idx, e_sat, e_k);
    chk({tag, "_idx"}, idx, e_idx);
    chk({tag, "_sat"}, sat, e_sat);
    chk({tag, "_lat"}, lat, e_k);
  endtask

  initial begin
    int idx, lat, sat, lv, dones;
    int seen[4];
    reset = 1'b1;
    st4 = 0; set4 = 0; fl4 = '0; st3 = 0; set3 = 0; fl3 = '0;
    seen = '{0, 0, 0, 0};
    repeat (3) @(negedge clk);
    chk("rst_busy4", busy4, 0); chk("rst_done4", done4, 0);
    chk("rst_idx4", idx4, 0);   chk("rst_sat4", sat4, 0);
    chk("rst_busy3", busy3, 0); chk("rst_done3", done3, 0);
    chk("rst_idx3", idx3, 0);   chk("rst_sat3", sat3, 0);
    reset = 1'b0;

    // Directed: deterministic offset, clause 2 unsatisfied -> 3 clauses examined
    pick(0, 4'b1011, 1, lat, idx, sat, lv);
    chk("dir1_idx", idx, 2); chk("dir1_sat", sat, 0); chk("dir1_lat", lat, 3);
    // All satisfied -> full wrap, index 0
    pick(0, 4'b1111, 1, lat, idx, sat, lv);
    chk("dir2_idx", idx, 0); chk("dir2_sat", sat, 1); chk("dir2_lat", lat, 4);

    // Random offset, only clause 3 unsatisfied
    for (int i = 0; i < 200; i++) begin
      pick_vs_model("r4_c3", 0, 4'b0111, 0, idx, lat);
      chk("r4_c3_fixed_idx", idx, 3);
      chk("r4_c3_lat_range", int'(lat >= 1 && lat <= 4), 1);
    end

    // Fully random flags and mode on N=4
    for (int i = 0; i < 100; i++)
      pick_vs_model("r4_any", 0, int'($urandom_range(15)), 1'($urandom_range(1)), idx, lat);

    // N=3, nothing satisfied: offset alone decides the index
    for (int i = 0; i < 300; i++) begin
      pick_vs_model("r3_zero", 1, 0, 0, idx, lat);
      chk("r3_lat1", lat, 1);
      chk("r3_idx_lt3", int'(idx < 3), 1);
      seen[idx]++;
    end
    chk("r3_seen0", int'(seen[0] > 0), 1);
    chk("r3_seen1", int'(seen[1] > 0), 1);
    chk("r3_seen2", int'(seen[2] > 0), 1);
    chk("r3_seen3", seen[3], 0);

    // Reset in the middle of a scan
    @(negedge clk);
    fl4 = 4'b0111; set4 = 1; st4 = 1;
    @(negedge clk); st4 = 0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("mrst_busy", busy4, 0); chk("mrst_done", done4, 0);
    chk("mrst_idx", idx4, 0);   chk("mrst_sat", sat4, 0);
    dones = 0;
    repeat (6) begin @(negedge clk); if (done4) dones++; end
    chk("mrst_no_done", dones, 0);
    pick(0, 4'b0111, 1, lat, idx, sat, lv);
    chk("mrst_fresh_idx", idx, 3); chk("mrst_fresh_sat", sat, 0); chk("mrst_fresh_lat", lat, 4);

    // Start while busy and flag changes during SCAN are both ignored
    @(negedge clk);
    fl4 = 4'b1101; set4 = 1; st4 = 1;
    @(negedge clk); fl4 = 4'b1111;
    @(negedge clk); st4 = 0;
    dones = 0;
    if (done4) dones++;
    repeat (10) begin @(negedge clk); if (done4) dones++; end
    chk("ign_one_done", dones, 1);
    chk("ign_idx", idx4, 1); chk("ign_sat", sat4, 0);
    chk("ign_idle", busy4, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
